multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter SUPPORT_ITYPE, default 1: 1 SHALL decode opcode 0010011 (I-type ALU); 0 SHALL treat it as illegal.
REQ-002 Parameter SUPPORT_JAL, default 1: 1 SHALL decode opcode 1101111 (jal); 0 SHALL treat it as illegal.
REQ-003 Parameter MEM_WAIT, default 1: 1 SHALL honour mem_ready; 0 SHALL ignore mem_ready and treat it as constant 1.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-005 op in 7: opcode from the instruction register, stable from DECODE until the next FETCH.
REQ-006 mem_ready in 1: memory completed the current access this cycle.
REQ-007 Strobe outputs, 1 bit each: pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal.
REQ-008 Select outputs, 2 bits each: alu_src_a, alu_src_b, result_src, alu_op, imm_src.
REQ-009 state_dbg out 4: current state encoding.

Function
REQ-010 Moore FSM; state encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
REQ-011 Any output not listed for a state SHALL be 0 in that state.
REQ-012 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=1 and pc_update=1 only when mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-013 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-014 DECODE next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- disabled or unknown opcode -> TRAP
REQ-015 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD when op=0000011, else MEMWRITE.
REQ-016 MEMREAD: adr_src=1, result_src=00. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
REQ-017 MEMWB: result_src=01, reg_write=1. Next state FETCH.
REQ-018 MEMWRITE: adr_src=1, result_src=00, mem_write=1, held every cycle until mem_ready=1. Then FETCH.
REQ-019 EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
REQ-020 EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
REQ-021 ALUWB: result_src=00, reg_write=1. Next state FETCH.
REQ-022 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next state ALUWB.
REQ-023 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next state FETCH.
REQ-024 TRAP: illegal=1 for exactly one cycle, with no reg_write, mem_write or pc_update. Next state FETCH.
REQ-025 imm_src SHALL be combinational from op in every state:
- 0000011 or 0010011 -> 00
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- otherwise 00
REQ-026 Instruction latency with mem_ready=1 throughout:
- lw: 5 cycles
- sw: 4 cycles
- R-type, I-type, jal: 4 cycles
- beq: 3 cycles
- illegal: 3 cycles
Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-027 mem_ready in any other state SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force state FETCH asynchronously, at any point including mid-instruction and during a memory wait.
REQ-029 While rst_n=0, all strobes SHALL be 0 (this overrides REQ-012). Select outputs SHALL hold their FETCH values.
REQ-030 After rst_n rises, the first rising clk edge with mem_ready=1 SHALL complete a fetch.
REQ-031 No state other than FETCH is reachable without passing through DECODE.

Verification
REQ-032 lw (op=0000011), mem_ready=1 -> state_dbg sequence 0,1,2,3,4; reg_write=1 only in state 4 with result_src=01; imm_src=00.
REQ-033 sw (op=0100011), mem_ready low 2 cycles in MEMWRITE -> sequence 0,1,2,5,5,5,0; mem_write=1 for all 3 MEMWRITE cycles; imm_src=01.
REQ-034 R-type, I-type, jal back-to-back -> sequences 0,1,6,7 / 0,1,8,7 / 0,1,9,7; alu_op=10 in states 6 and 8; pc_update=1 in state 9.
REQ-035 beq -> sequence 0,1,10; branch=1 and alu_op=01 in state 10; then FETCH.
REQ-036 SUPPORT_JAL=0 with op=1101111, and separately op=1111111 -> sequence 0,1,11,0; illegal=1 for exactly one cycle; reg_write, mem_write and pc_update stay 0.
REQ-037 rst_n pulsed low while in MEMREAD with mem_ready=0 -> state_dbg=0 immediately without a clock edge; all strobes 0 while rst_n is low.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch, decode and the per-class
// execute/memory/writeback steps, and drives the datapath selects and strobes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instruction at PC; latch IR and advance PC on ready
//   DECODE   | register read; ALU computes PC-relative target
//   MEMADR   | ALU forms load/store effective address
//   MEMREAD  | load data access, wait for memory
//   MEMWB    | write load data into the register file
//   MEMWRITE | store data access, mem_write held until memory accepts
//   EXECUTER | register-register ALU operation
//   ALUWB    | write ALU result into the register file
//   EXECUTEI | register-immediate ALU operation
//   JAL      | jump: PC takes target, link address prepared
//   BEQ      | compare and conditionally branch
//   TRAP     | unsupported opcode, single-cycle illegal pulse
module multicycle_controller #(
    parameter int unsigned SUPPORT_ITYPE = 1,
    parameter int unsigned SUPPORT_JAL   = 1,
    parameter int unsigned MEM_WAIT      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       pc_update,
    output logic       branch,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       illegal,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [3:0] state_dbg
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state;
    state_t state_next;
    logic   ready;

    // Without a wait-capable memory every access completes in one cycle.
    assign ready     = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state_dbg = state;

    // State register; reset returns to FETCH from anywhere, even mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // Reset is the only way to be in FETCH while rst_n is low, so
                // gating the fetch strobes here keeps every strobe quiet in reset.
                ir_write   = ready & rst_n;
                pc_update  = ready & rst_n;
                if (ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = (SUPPORT_ITYPE != 0) ? S_EXECUTEI : S_TRAP;
                    OP_JAL:            state_next = (SUPPORT_JAL != 0) ? S_JAL : S_TRAP;
                    OP_BEQ:            state_next = S_BEQ;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a full-featured instance and a stripped one
// (no I-type, no jal, no memory wait) share the same stimulus; a route-based
// model predicts both every cycle, and literal state strings pin key scenarios.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BQ   = 7'b1100011;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       mem_ready;

    logic [1:0] pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0] alu_src_a [2];
    logic [1:0] alu_src_b [2];
    logic [1:0] result_src [2];
    logic [1:0] alu_op [2];
    logic [1:0] imm_src [2];
    logic [3:0] state_dbg [2];

    int n_pass  = 0;
    int n_total = 0;

    multicycle_controller #(.SUPPORT_ITYPE(1), .SUPPORT_JAL(1), .MEM_WAIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_update(pc_update[0]), .branch(branch[0]), .ir_write(ir_write[0]),
        .reg_write(reg_write[0]), .mem_write(mem_write[0]), .adr_src(adr_src[0]),
        .illegal(illegal[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .result_src(result_src[0]), .alu_op(alu_op[0]), .imm_src(imm_src[0]),
        .state_dbg(state_dbg[0])
    );

    multicycle_controller #(.SUPPORT_ITYPE(0), .SUPPORT_JAL(0), .MEM_WAIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_update(pc_update[1]), .branch(branch[1]), .ir_write(ir_write[1]),
        .reg_write(reg_write[1]), .mem_write(mem_write[1]), .adr_src(adr_src[1]),
        .illegal(illegal[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .result_src(result_src[1]), .alu_op(alu_op[1]), .imm_src(imm_src[1]),
        .state_dbg(state_dbg[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        n_total++;
        if (got != exp) begin
            $display("FAIL %s got=%s expected=%s", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- model ----------------
    bit sup_i [2] = '{1'b1, 1'b0};
    bit sup_j [2] = '{1'b1, 1'b0};
    bit mwait [2] = '{1'b1, 1'b0};
    int ms [2]    = '{0, 0};
    int rt [2][3];
    int rlen [2]  = '{0, 0};
    int rpos [2]  = '{0, 0};

    // The path an instruction takes after DECODE, as a list of state numbers.
    task automatic plan(input int i, input logic [6:0] opv);
        rlen[i] = 1;
        rt[i][0] = 11;
        if (opv == LW) begin
            rt[i][0] = 2; rt[i][1] = 3; rt[i][2] = 4; rlen[i] = 3;
        end else if (opv == SW) begin
            rt[i][0] = 2; rt[i][1] = 5; rlen[i] = 2;
        end else if (opv == RT) begin
            rt[i][0] = 6; rt[i][1] = 7; rlen[i] = 2;
        end else if (opv == IT && sup_i[i]) begin
            rt[i][0] = 8; rt[i][1] = 7; rlen[i] = 2;
        end else if (opv == JL && sup_j[i]) begin
            rt[i][0] = 9; rt[i][1] = 7; rlen[i] = 2;
        end else if (opv == BQ) begin
            rt[i][0] = 10; rlen[i] = 1;
        end
    endtask

    task automatic step(input int i);
        bit rdy;
        rdy = mwait[i] ? mem_ready : 1'b1;
        if (ms[i] == 0) begin
            if (rdy) ms[i] = 1;
        end else if (ms[i] == 1) begin
            plan(i, op);
            ms[i] = rt[i][0];
            rpos[i] = 1;
        end else if ((ms[i] == 3 || ms[i] == 5) && !rdy) begin
            ms[i] = ms[i];
        end else if (rpos[i] < rlen[i]) begin
            ms[i] = rt[i][rpos[i]];
            rpos[i]++;
        end else begin
            ms[i] = 0;
        end
    endtask

    function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit rstn,
                                             input logic [6:0] opv);
        logic pc, br, ir, rw, mw, ad, il;
        logic [1:0] a, b, rs, ao, im;
        {pc, br, ir, rw, mw, ad, il} = 7'b0;
        {a, b, rs, ao} = 8'b0;
        case (st)
            0:  begin b = 2'b10; rs = 2'b10; ir = rdy & rstn; pc = rdy & rstn; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  ad = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin ad = 1'b1; mw = 1'b1; end
            6:  begin a = 2'b10; ao = 2'b10; end
            7:  rw = 1'b1;
            8:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
            9:  begin a = 2'b01; b = 2'b10; pc = 1'b1; end
            10: begin a = 2'b10; ao = 2'b01; br = 1'b1; end
            11: il = 1'b1;
            default: ;
        endcase
        if (opv == SW)      im = 2'b01;
        else if (opv == BQ) im = 2'b10;
        else if (opv == JL) im = 2'b11;
        else                im = 2'b00;
        return {pc, br, ir, rw, mw, ad, il, a, b, rs, ao, im};
    endfunction

    function automatic logic [16:0] got_vec(input int i);
        return {pc_update[i], branch[i], ir_write[i], reg_write[i], mem_write[i], adr_src[i],
                illegal[i], alu_src_a[i], alu_src_b[i], result_src[i], alu_op[i], imm_src[i]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ms[i] = 0; rlen[i] = 0; rpos[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) step(i);
        end
    end

    // ---------------- compare and history ----------------
    bit         cmp_en = 1'b0;
    bit         rec = 1'b0;
    logic [3:0] h0 [$];
    logic [3:0] h1 [$];
    int cnt_ill [2];
    int cnt_rw [2];
    int cnt_mw [2];
    int cnt_pcx [2];

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                int est;
                bit rdy;
                est = rst_n ? ms[i] : 0;
                rdy = mwait[i] ? mem_ready : 1'b1;
                chk($sformatf("state_dut%0d", i), 32'(state_dbg[i]), 32'(est));
                chk($sformatf("ctrl_dut%0d_st%0d", i, est), 32'(got_vec(i)),
                    32'(exp_ctrl(est, rdy, rst_n, op)));
            end
        end
        if (rec) begin
            h0.push_back(state_dbg[0]);
            h1.push_back(state_dbg[1]);
            for (int i = 0; i < 2; i++) begin
                cnt_ill[i] += int'(illegal[i]);
                cnt_rw[i]  += int'(reg_write[i]);
                cnt_mw[i]  += int'(mem_write[i]);
                if (state_dbg[i] != 4'd0) cnt_pcx[i] += int'(pc_update[i]);
            end
        end
    end

    function automatic string seq_str(input int which);
        string s;
        s = "";
        if (which == 0) foreach (h0[k]) s = {s, $sformatf("%h", h0[k])};
        else            foreach (h1[k]) s = {s, $sformatf("%h", h1[k])};
        return s;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cyc(input logic mr);
        mem_ready = mr;
        @(posedge clk);
        #2;
    endtask

    task automatic start_rec();
        h0.delete(); h1.delete();
        for (int i = 0; i < 2; i++) begin
            cnt_ill[i] = 0; cnt_rw[i] = 0; cnt_mw[i] = 0; cnt_pcx[i] = 0;
        end
        rec = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [6:0] opv, input int n);
        op = opv;
        for (int k = 0; k < n; k++) cyc(1'b1);
    endtask

    initial begin
        rst_n = 1'b1;
        mem_ready = 1'b1;
        op = LW;
        #1 rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("reset_state", 32'(state_dbg[0]), 32'd0);
        chk("reset_strobes", 32'({pc_update[0], branch[0], ir_write[0], reg_write[0],
                                  mem_write[0], adr_src[0], illegal[0]}), 32'd0);
        chk("reset_selects", 32'({alu_src_a[0], alu_src_b[0], result_src[0], alu_op[0]}),
            32'b00_10_10_00);
        @(posedge clk);
        #2;
        do_reset();

        // jal: decoded on the full instance, trapped on the stripped one
        start_rec(); run(JL, 4); rec = 1'b0;
        chk_str("jal_seq_dut0", seq_str(0), "0197");
        chk_str("jal_seq_dut1", seq_str(1), "01b0");
        chk("jal_off_illegal_cnt", 32'(cnt_ill[1]), 32'd1);
        chk("jal_off_rw_mw_cnt", 32'(cnt_rw[1] + cnt_mw[1] + cnt_pcx[1]), 32'd0);

        // lw, no waits
        do_reset();
        op = LW;
        #1 chk("lw_imm_src", 32'(imm_src[0]), 32'd0);
        start_rec(); run(LW, 5); rec = 1'b0;
        chk_str("lw_seq", seq_str(0), "01234");
        chk("lw_reg_write_cnt", 32'(cnt_rw[0]), 32'd1);

        // sw with two wait cycles in MEMWRITE, then a stalled fetch
        do_reset();
        op = SW;
        #1 chk("sw_imm_src", 32'(imm_src[0]), 32'd1);
        start_rec();
        cyc(1); cyc(1); cyc(1); cyc(0); cyc(0); cyc(1); cyc(0);
        rec = 1'b0;
        chk_str("sw_wait_seq_dut0", seq_str(0), "0125550");
        chk("sw_mem_write_cnt", 32'(cnt_mw[0]), 32'd3);
        chk_str("sw_nowait_seq_dut1", seq_str(1), "0125012");

        // R-type, I-type, jal back to back
        do_reset();
        start_rec(); run(RT, 4); run(IT, 4); run(JL, 4); rec = 1'b0;
        chk_str("rij_seq_dut0", seq_str(0), "016701870197");
        chk_str("rij_seq_dut1", seq_str(1), "016701b01b01");

        // beq
        do_reset();
        start_rec(); run(BQ, 4); rec = 1'b0;
        chk_str("beq_seq", seq_str(0), "01a0");

        // unknown opcode
        do_reset();
        start_rec(); run(BAD, 4); rec = 1'b0;
        chk_str("bad_seq_dut0", seq_str(0), "01b0");
        chk_str("bad_seq_dut1", seq_str(1), "01b0");
        chk("bad_illegal_cnt", 32'(cnt_ill[0]), 32'd1);
        chk("bad_side_effects", 32'(cnt_rw[0] + cnt_mw[0] + cnt_pcx[0]), 32'd0);

        // lw with a fetch stall and a read stall
        do_reset();
        op = LW;
        start_rec();
        cyc(0); cyc(1); cyc(1); cyc(1); cyc(0); cyc(1); cyc(1);
        rec = 1'b0;
        chk_str("lw_wait_seq", seq_str(0), "0012334");

        // asynchronous reset while stalled in MEMREAD
        do_reset();
        run(LW, 3);
        mem_ready = 1'b0;
        #1 chk("memread_before_reset", 32'(state_dbg[0]), 32'd3);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("async_reset_state", 32'(state_dbg[0]), 32'd0);
        chk("async_reset_strobes", 32'({pc_update[0], branch[0], ir_write[0], reg_write[0],
                                        mem_write[0], adr_src[0], illegal[0]}), 32'd0);
        chk("async_reset_state_dut1", 32'(state_dbg[1]), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        start_rec(); run(BQ, 4); rec = 1'b0;
        chk_str("after_reset_seq", seq_str(0), "01a0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
